// File: rtl/demux_rr_dispatcher.sv
// 1-to-4 dispatch stage: routes a valid/ready word stream into four one-entry
// registered channel slots, by round-robin with skip-if-busy or by explicit destination.
module demux_rr_dispatcher #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_use_dest,
   input  logic [1:0]            in_dest,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic [1:0]            last_sel,
   output logic [CNT_W-1:0]      accept_cnt
);

   logic [3:0]        full_q, full_d;
   logic [3:0]        free;
   logic [DATA_W-1:0] slot_q [4];
   logic [DATA_W-1:0] slot_d [4];
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [1:0]        last_sel_q, last_sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        rr_target, target, scan_idx;
   logic              rr_found;
   logic              accept;

   // A slot draining this cycle can be refilled on the same edge.
   assign free = ~full_q | out_ready;

   always_comb begin
      rr_target = rr_ptr_q;
      rr_found  = 1'b0;
      scan_idx  = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (!rr_found && free[scan_idx]) begin
            rr_target = scan_idx;
            rr_found  = 1'b1;
         end
      end
   end

   assign target   = in_use_dest ? in_dest : rr_target;
   assign in_ready = in_use_dest ? free[in_dest] : |free;
   assign accept   = in_valid & in_ready;

   always_comb begin
      full_d     = full_q & ~out_ready;
      slot_d     = slot_q;
      rr_ptr_d   = rr_ptr_q;
      last_sel_d = last_sel_q;
      cnt_d      = cnt_q;
      if (accept) begin
         full_d[target] = 1'b1;
         slot_d[target] = in_data;
         last_sel_d     = target;
         cnt_d          = cnt_q + CNT_W'(1);
         if (!in_use_dest) begin
            rr_ptr_d = target + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= '0;
         rr_ptr_q   <= '0;
         last_sel_q <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         full_q     <= full_d;
         rr_ptr_q   <= rr_ptr_d;
         last_sel_q <= last_sel_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_out
      assign out_data[i*DATA_W +: DATA_W] = slot_q[i];
   end

   assign out_valid  = full_q;
   assign last_sel   = last_sel_q;
   assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed, table-driven bench for demux_rr_dispatcher plus a counter-wrap sequence.
module tb_demux_rr_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_use_dest;
   logic [1:0]  in_dest;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic [1:0]  last_sel;
   logic [15:0] accept_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   demux_rr_dispatcher #(
      .DATA_W (8),
      .CNT_W  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_use_dest (in_use_dest),
      .in_dest     (in_dest),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .last_sel    (last_sel),
      .accept_cnt  (accept_cnt)
   );

   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  dat;
      logic        ud;
      logic [1:0]  dest;
      logic [3:0]  ordy;
      logic        e_rdy;
      logic [3:0]  e_ov;
      logic [1:0]  e_ls;
      logic [15:0] e_cnt;
      logic [1:0]  e_ch;
      logic [7:0]  e_dat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [7:0] d, input logic ud,
                      input logic [1:0] de, input logic [3:0] ordy, input logic e_rdy,
                      input logic [3:0] e_ov, input logic [1:0] e_ls, input logic [15:0] e_cnt,
                      input logic [1:0] e_ch, input logic [7:0] e_dat);
      vec_t x;
      x.rst = r; x.vld = v; x.dat = d; x.ud = ud; x.dest = de; x.ordy = ordy;
      x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_ls = e_ls; x.e_cnt = e_cnt;
      x.e_ch = e_ch; x.e_dat = e_dat;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_use_dest = 1'b0; in_dest = '0;
      out_ready = 4'hF;

      //   rst vld dat   ud de  ordy    rdy ov       ls  cnt ch dat
      add(1, 0, 8'h00, 0, 0, 4'hF,    1, 4'b0000, 0,  0, 0, 8'h00); // reset
      // round-robin through all channels
      add(0, 1, 8'hA0, 0, 0, 4'hF,    1, 4'b0001, 0,  1, 0, 8'hA0);
      add(0, 1, 8'hA1, 0, 0, 4'hF,    1, 4'b0010, 1,  2, 1, 8'hA1);
      add(0, 1, 8'hA2, 0, 0, 4'hF,    1, 4'b0100, 2,  3, 2, 8'hA2);
      add(0, 1, 8'hA3, 0, 0, 4'hF,    1, 4'b1000, 3,  4, 3, 8'hA3);
      add(0, 1, 8'hA4, 0, 0, 4'hF,    1, 4'b0001, 0,  5, 0, 8'hA4);
      add(0, 0, 8'h00, 0, 0, 4'hF,    1, 4'b0000, 0,  5, 0, 8'hA4);
      // dest mode backpressure, then same-edge drain/refill
      add(0, 1, 8'h11, 1, 2, 4'b1011, 1, 4'b0100, 2,  6, 2, 8'h11);
      add(0, 1, 8'h22, 1, 2, 4'b1011, 0, 4'b0100, 2,  6, 2, 8'h11);
      add(0, 1, 8'h22, 1, 2, 4'hF,    1, 4'b0100, 2,  7, 2, 8'h22);
      add(0, 0, 8'h00, 0, 0, 4'hF,    1, 4'b0000, 2,  7, 2, 8'h22);
      // fill all slots with no downstream ready, then skip to the only free one
      add(0, 1, 8'h31, 0, 0, 4'h0,    1, 4'b0010, 1,  8, 1, 8'h31);
      add(0, 1, 8'h32, 0, 0, 4'h0,    1, 4'b0110, 2,  9, 2, 8'h32);
      add(0, 1, 8'h33, 0, 0, 4'h0,    1, 4'b1110, 3, 10, 3, 8'h33);
      add(0, 1, 8'h34, 0, 0, 4'h0,    1, 4'b1111, 0, 11, 0, 8'h34);
      add(0, 1, 8'h35, 0, 0, 4'h0,    0, 4'b1111, 0, 11, 1, 8'h31);
      add(0, 1, 8'h35, 0, 0, 4'b0100, 1, 4'b1111, 2, 12, 2, 8'h35);
      add(0, 0, 8'h00, 0, 0, 4'hF,    1, 4'b0000, 2, 12, 2, 8'h35);
      // mixed modes: bring rr pointer to 1, dest word leaves it there
      add(0, 1, 8'h40, 0, 0, 4'hF,    1, 4'b1000, 3, 13, 3, 8'h40);
      add(0, 1, 8'h41, 0, 0, 4'hF,    1, 4'b0001, 0, 14, 0, 8'h41);
      add(0, 1, 8'h42, 1, 3, 4'hF,    1, 4'b1000, 3, 15, 3, 8'h42);
      add(0, 1, 8'h43, 0, 3, 4'hF,    1, 4'b0010, 1, 16, 1, 8'h43);
      // reset with ch1 and ch3 holding words
      add(0, 1, 8'h50, 1, 3, 4'h0,    1, 4'b1010, 3, 17, 3, 8'h50);
      add(1, 1, 8'h51, 0, 0, 4'h0,    0, 4'b0000, 0,  0, 3, 8'h00);
      add(0, 1, 8'h52, 0, 0, 4'hF,    1, 4'b0001, 0,  1, 0, 8'h52);
      add(0, 0, 8'h00, 0, 0, 4'hF,    1, 4'b0000, 0,  1, 0, 8'h52);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].dat;
         in_use_dest = vecs[i].ud; in_dest = vecs[i].dest; out_ready = vecs[i].ordy;
         #1;
         if (!vecs[i].rst) chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d last_sel", i), 32'(last_sel), 32'(vecs[i].e_ls));
         chk($sformatf("v%0d accept_cnt", i), 32'(accept_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d out_data[ch%0d]", i, vecs[i].e_ch),
             32'(out_data[vecs[i].e_ch*8 +: 8]), 32'(vecs[i].e_dat));
      end

      // counter wrap: count is 1 here, 65534 more accepts reach 65535
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_use_dest = 1'b0; out_ready = 4'hF;
      repeat (65534) @(posedge clk);
      #1;
      chk("wrap cnt_max", 32'(accept_cnt), 32'd65535);
      @(posedge clk);
      #1;
      chk("wrap cnt_zero", 32'(accept_cnt), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("wrap cnt_hold", 32'(accept_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Upstream dispatch stage for the 1-to-4 demultiplexer path. Accepts a valid/ready word stream and routes each word to one of four output channels. Routing is either round-robin with skip-if-busy, or explicit via a destination field. Each channel has a one-entry registered holding slot with its own valid/ready handshake. The block also publishes the last selected channel and a running accept count.

Parameters:
DATA_W, 8, width of each data word.
CNT_W, 16, width of the accepted-word counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  block can accept this cycle.
in_data  input  DATA_W  upstream word.
in_use_dest  input  1  1 = route to in_dest; 0 = round-robin.
in_dest  input  2  destination channel when in_use_dest=1.
out_valid  output  4  per-channel slot full.
out_ready  input  4  per-channel downstream ready.
out_data  output  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
last_sel  output  2  channel that took the most recent accepted word.
accept_cnt  output  CNT_W  number of words accepted, wrapping.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - all full flags to 0, so out_valid=4'b0000;
  - out_data=0, last_sel=0, accept_cnt=0;
  - rr_ptr=0.
- Reset mid-operation discards held words. No handshake completes on a reset cycle.
- Slot i is free when !full[i] || out_ready[i]. Simultaneous drain and refill of the same slot in one cycle is allowed.
- Target selection (combinational):
  - Dest mode: target = in_dest. in_ready = free[in_dest].
  - Round-robin mode: target = first free channel, scanning rr_ptr, rr_ptr+1, ... with wrap 3→0. in_ready = |free.
- in_ready does not depend on in_valid. A combinational path from out_ready to in_ready is permitted.
- Accept occurs when in_valid && in_ready at a clk edge. On accept:
  - slot[target] <= in_data and full[target] <= 1;
  - last_sel <= target;
  - accept_cnt <= accept_cnt+1, wrapping at 2^CNT_W to 0.
  - In round-robin mode, rr_ptr <= target+1 mod 4. In dest mode, rr_ptr is unchanged.
- Drain: out_valid[i] && out_ready[i] at an edge clears full[i], unless the same edge refills slot i, in which case it stays 1.
- Latency: a word accepted at edge k appears on out_valid/out_data immediately after edge k (one register stage). No combinational path from in_data to out_data.
- Stability: while out_valid[i] && !out_ready[i], out_data for channel i holds constant.
- Ordering: words sent to the same channel leave in acceptance order. There is no cross-channel ordering guarantee.
- When in_valid=0, no state changes except drains.
- in_dest is ignored when in_use_dest=0.

Test Plan:
1. Round-robin sequence: out_ready=4'b1111, in_use_dest=0, send 0xA0..0xA4 back-to-back → words appear on ch0,1,2,3,0, each one cycle after accept. in_ready stays 1. last_sel ends 0. accept_cnt=5.
2. Dest backpressure: in_use_dest=1, in_dest=2, out_ready[2]=0, send 0x11 → out_valid=4'b0100, in_ready=0 while 0x22 is presented. Raise out_ready[2] → in_ready=1 in the same cycle, 0x11 drains and 0x22 loads on one edge, out_valid[2] stays 1.
3. Skip-busy and full: out_ready=0, send 4 round-robin words → out_valid=4'b1111 and in_ready=0. Set out_ready=4'b0100 → next word lands in ch2.
4. Mixed modes: rr_ptr=1, send a dest word to ch3, then a round-robin word (all free) → round-robin word goes to ch1.
5. Reset mid-operation: with ch1 and ch3 full, assert rst for one cycle → out_valid=0, accept_cnt=0, last_sel=0. Next round-robin word goes to ch0.
6. Counter wrap: preload by 65535 accepts, then one more → accept_cnt=0.
